vec_pair_writer: RTL and testbench

- Write-side counterpart of the dot-product memory reader.
- Accepts a valid/ready stream of element pairs (vector A element, vector B element) and writes them at sequential addresses into the mem1/mem2 write ports.
- Loads one full image of DEPTH words per start command, then signals completion so the reader may run.
- Sits between the host/test-stream source and the mem1/mem2 instances.

---
 rtl/vec_pair_writer.sv | 151 +++++++++++++++
 tb/tb_vec_pair_writer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vec_pair_writer.sv
// vec_pair_writer: accepts a valid/ready stream of (A, B) element pairs and writes
// each pair at the same sequential address into the mem1/mem2 write ports. One
// start command loads one image of DEPTH words, then pulses loading_done.
module vec_pair_writer #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned VECTOR_WIDTH = 4,
    parameter int unsigned DEPTH        = VECTOR_WIDTH * DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_loading,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data_a,
    input  logic [DATA_WIDTH-1:0] s_data_b,
    input  logic                  s_last,
    output logic                  wr_en_mem1,
    output logic                  wr_en_mem2,
    output logic [ADDR_WIDTH-1:0] wr_addr_mem1,
    output logic [ADDR_WIDTH-1:0] wr_addr_mem2,
    output logic [DATA_WIDTH-1:0] wr_data_mem1,
    output logic [DATA_WIDTH-1:0] wr_data_mem2,
    output logic                  busy,
    output logic                  loading_done,
    output logic                  short_err,
    output logic [2:0]            element_count,
    output logic [ADDR_WIDTH:0]   words_written
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [2:0]            LastElem = 3'(VECTOR_WIDTH - 1);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;          // address of the next accepted pair
    logic [2:0]            elem_q, elem_d;          // vector index of the next accepted pair
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_a_q, wr_data_a_d;
    logic [DATA_WIDTH-1:0] wr_data_b_q, wr_data_b_d;
    logic [2:0]            elem_cnt_q, elem_cnt_d;
    logic [ADDR_WIDTH:0]   words_q, words_d;
    logic                  short_err_q, short_err_d;
    logic                  done_q, done_d;
    logic                  xfer;

    assign s_ready = (state_q == StLoad);
    assign busy    = (state_q != StIdle);
    assign xfer    = s_valid & s_ready;

    // Next-state logic: control FSM, address counter and registered write port
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        elem_d      = elem_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_a_d = wr_data_a_q;
        wr_data_b_d = wr_data_b_q;
        elem_cnt_d  = elem_cnt_q;
        words_d     = words_q;
        short_err_d = short_err_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                addr_d     = '0;
                elem_d     = '0;
                elem_cnt_d = '0;
                // Status of the previous load stays visible until a new start is taken
                if (start_loading) begin
                    state_d     = StLoad;
                    words_d     = '0;
                    short_err_d = 1'b0;
                end
            end
            StLoad: begin
                if (xfer) begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = addr_q;
                    wr_data_a_d = s_data_a;
                    wr_data_b_d = s_data_b;
                    elem_cnt_d  = elem_q;
                    elem_d      = (elem_q == LastElem) ? 3'd0 : elem_q + 3'd1;
                    words_d     = words_q + 1'b1;
                    // A full image ends the load whatever s_last says
                    if (addr_q == LastAddr) begin
                        state_d = StDone;
                    end else if (s_last) begin
                        short_err_d = 1'b1;
                        state_d     = StDone;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; asynchronous reset drops any write in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            elem_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_a_q <= '0;
            wr_data_b_q <= '0;
            elem_cnt_q  <= '0;
            words_q     <= '0;
            short_err_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            elem_q      <= elem_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_a_q <= wr_data_a_d;
            wr_data_b_q <= wr_data_b_d;
            elem_cnt_q  <= elem_cnt_d;
            words_q     <= words_d;
            short_err_q <= short_err_d;
            done_q      <= done_d;
        end
    end

    assign wr_en_mem1    = wr_en_q;
    assign wr_en_mem2    = wr_en_q;
    assign wr_addr_mem1  = wr_addr_q;
    assign wr_addr_mem2  = wr_addr_q;
    assign wr_data_mem1  = wr_data_a_q;
    assign wr_data_mem2  = wr_data_b_q;
    assign element_count = elem_cnt_q;
    assign words_written = words_q;
    assign short_err     = short_err_q;
    assign loading_done  = done_q;

endmodule

// File: tb/tb_vec_pair_writer.sv
// Bench for vec_pair_writer: directed load scenarios with random data and gaps,
// checked against a list-of-transfers reference (k-th accepted pair -> address k).
module tb_vec_pair_writer;

    localparam int DW    = 8;
    localparam int VW    = 4;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_loading = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data_a = '0;
    logic [DW-1:0] s_data_b = '0;
    logic          s_last = 1'b0;
    logic          wr_en_mem1, wr_en_mem2;
    logic [AW-1:0] wr_addr_mem1, wr_addr_mem2;
    logic [DW-1:0] wr_data_mem1, wr_data_mem2;
    logic          busy, loading_done, short_err;
    logic [2:0]    element_count;
    logic [AW:0]   words_written;

    vec_pair_writer #(
        .DATA_WIDTH  (DW),
        .VECTOR_WIDTH(VW),
        .DEPTH       (DEPTH),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_loading(start_loading),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data_a     (s_data_a),
        .s_data_b     (s_data_b),
        .s_last       (s_last),
        .wr_en_mem1   (wr_en_mem1),
        .wr_en_mem2   (wr_en_mem2),
        .wr_addr_mem1 (wr_addr_mem1),
        .wr_addr_mem2 (wr_addr_mem2),
        .wr_data_mem1 (wr_data_mem1),
        .wr_data_mem2 (wr_data_mem2),
        .busy         (busy),
        .loading_done (loading_done),
        .short_err    (short_err),
        .element_count(element_count),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            c;
        logic          en2;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [2:0]    el;
        logic [AW:0]   ww;
    } wr_t;

    wr_t wq[$];          // observed writes
    int  dq[$];          // cycles where loading_done was seen
    int  exp_a[$];
    int  exp_b[$];
    int  xq[$];          // cycle in which each transfer's write must appear

    // Capture write strobes and completion pulses away from the active edge
    always @(negedge clk) begin
        if (wr_en_mem1 === 1'b1)
            wq.push_back('{c: cyc, en2: wr_en_mem2, a1: wr_addr_mem1, a2: wr_addr_mem2,
                           d1: wr_data_mem1, d2: wr_data_mem2, el: element_count,
                           ww: words_written});
        if (loading_done === 1'b1) dq.push_back(cyc);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({s_ready, wr_en_mem1, wr_en_mem2, wr_addr_mem1, wr_addr_mem2, wr_data_mem1,
                    wr_data_mem2, busy, loading_done, short_err, element_count,
                    words_written});
    endfunction

    // Source presents pairs while idle; nothing may be accepted or written
    task automatic idle_stray();
        wq.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_valid  = 1'b1;
            s_data_a = DW'($urandom);
            s_data_b = DW'($urandom);
            if (i > 0) begin
                check("idle_s_ready", 64'(s_ready), 64'd0);
                check("idle_busy", 64'(busy), 64'd0);
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        check("idle_no_write", 64'(wq.size()), 64'd0);
    endtask

    // mode 0: back-to-back a=k b=2k, 1: alternate beats, 2: random gaps/data
    task automatic do_load(input int mode, input int last_idx, input int stray_at);
        int  k;
        int  beat;
        bit  fin;
        bit  v;
        int  n;
        wq.delete(); dq.delete(); exp_a.delete(); exp_b.delete(); xq.delete();
        @(negedge clk);
        start_loading = 1'b1;
        @(negedge clk);
        start_loading = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_short_clr", 64'(short_err), 64'd0);
        check("start_words_clr", 64'(words_written), 64'd0);
        k = 0; beat = 0; fin = 1'b0;
        while (!fin && beat < 400) begin
            check("load_s_ready", 64'(s_ready), 64'd1);
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = beat[0];
            else                v = ($urandom_range(0, 2) != 0);
            s_valid       = v;
            start_loading = (beat == stray_at);
            if (mode == 0) begin
                s_data_a = DW'(k);
                s_data_b = DW'(2 * k);
            end else begin
                s_data_a = DW'($urandom);
                s_data_b = DW'($urandom);
            end
            if (!v)                 s_last = 1'($urandom_range(0, 1));
            else if (k == last_idx) s_last = 1'b1;
            else if (k == DEPTH-1)  s_last = 1'($urandom_range(0, 1));
            else                    s_last = 1'b0;
            if (v) begin
                exp_a.push_back(int'(s_data_a));
                exp_b.push_back(int'(s_data_b));
                xq.push_back(cyc + 1);
                if (k == DEPTH - 1 || k == last_idx) fin = 1'b1;
                k++;
            end
            beat++;
            @(negedge clk);
        end
        s_valid = 1'b0; s_last = 1'b0; start_loading = 1'b0;
        if (!fin) check("load_timeout", 64'd0, 64'd1);
        repeat (3) @(negedge clk);
        n = exp_a.size();
        check("write_count", 64'(wq.size()), 64'(n));
        for (int i = 0; i < n && i < wq.size(); i++) begin
            check("wr_en_mem2", 64'(wq[i].en2), 64'd1);
            check("wr_addr_mem1", 64'(wq[i].a1), 64'(i));
            check("wr_addr_mem2", 64'(wq[i].a2), 64'(i));
            check("wr_data_mem1", 64'(wq[i].d1), 64'(exp_a[i]));
            check("wr_data_mem2", 64'(wq[i].d2), 64'(exp_b[i]));
            check("element_count", 64'(wq[i].el), 64'(i % VW));
            check("words_running", 64'(wq[i].ww), 64'(i + 1));
            check("write_cycle", 64'(wq[i].c), 64'(xq[i]));
        end
        check("done_pulses", 64'(dq.size()), 64'd1);
        if (dq.size() > 0 && n > 0) check("done_cycle", 64'(dq[0]), 64'(xq[n-1] + 1));
        check("words_final", 64'(words_written), 64'(n));
        check("short_err", 64'(short_err), 64'(n < DEPTH));
        check("end_busy", 64'(busy), 64'd0);
        check("end_s_ready", 64'(s_ready), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;

        idle_stray();
        do_load(0, -1, -1);                   // full image, a=i b=2i
        do_load(1, -1, -1);                   // alternate-beat backpressure
        do_load(0, 9, -1);                    // early s_last on beat 9
        do_load(2, -1, 5);                    // random gaps, stray start mid-load
        idle_stray();

        // Reset after 5 transfers, then a fresh load must begin at address 0
        @(negedge clk);
        start_loading = 1'b1;
        @(negedge clk);
        start_loading = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid  = 1'b1;
            s_data_a = DW'($urandom);
            s_data_b = DW'($urandom);
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        s_valid = 1'b0;
        #1 check("midload_reset", all_outs(), 64'd0);
        @(negedge clk);
        check("reset_held", all_outs(), 64'd0);
        rst_n = 1'b1;
        do_load(2, -1, -1);
        do_load(2, int'($urandom_range(0, 30)), -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
